// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared state type, defaults and sizing helper
// for the FFT frame scheduler.
package fft_sched_pkg;

  localparam int DEF_DATA_W  = 48;
  localparam int DEF_FFT_LEN = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FILL,
    S_READ,
    S_DONE,
    S_HALT
  } sched_state_t;

  function automatic int cnt_w(input int len);
    return $clog2(len) + 1;
  endfunction

endpackage

// File: rtl/fft_sched_skid.sv
// fft_sched_skid: two-entry output buffer in front of the FFT stream.
// The head register drives the stream; the tail absorbs one beat under stall.
module fft_sched_skid #(
  parameter int DATA_W = 48
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              tail_v;
  logic [DATA_W-1:0] tail_d;
  logic              push;
  logic              pop;

  assign in_ready = !tail_v;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign occ      = {1'b0, out_valid} + {1'b0, tail_v};

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      tail_v    <= 1'b0;
      tail_d    <= '0;
    end else if (pop) begin
      if (tail_v) begin
        out_data <= tail_d;
        tail_v   <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) out_data <= in_data;
      end
    end else if (push) begin
      if (out_valid) begin
        tail_v <= 1'b1;
        tail_d <= in_data;
      end else begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: cuts FIFO samples into fixed-length frames for the FFT core.
// Reads are throttled so the two-entry output buffer can never overflow.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FFT_LEN     = DEF_FFT_LEN,
  parameter int LVL_W       = 11,
  parameter int FILL_THRESH = 1500,
  parameter int MAX_FRAMES  = 6
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              start_en,
  input  logic [LVL_W-1:0]  fifo_level,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_valid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int            CW   = cnt_w(FFT_LEN);
  localparam logic [CW-1:0] LEN  = CW'(FFT_LEN);
  localparam logic [CW-1:0] LAST = CW'(FFT_LEN - 1);
  localparam logic [31:0]   THR  = 32'(FILL_THRESH);
  localparam logic [31:0]   MAXF = 32'(MAX_FRAMES);

  sched_state_t  state;
  logic [CW-1:0] issued;
  logic [CW-1:0] sent;
  logic          inflight;
  logic          pop;
  logic          buf_rdy;
  logic          lvl_ok;
  logic          last_run;
  logic [1:0]    buf_occ;
  logic [1:0]    load;

  assign pop = m_axis_tvalid & m_axis_tready;

  // The slot freed by this cycle's handshake already counts as free,
  // which is what sustains one sample per cycle.
  assign load = buf_occ - {1'b0, pop} + {1'b0, inflight};

  assign fifo_rd_en = (state == S_READ) & (issued < LEN)
                    & !fifo_empty & (load < 2'd2);

  assign m_axis_tlast = m_axis_tvalid & (sent == LAST);
  assign lvl_ok       = 32'(fifo_level) >= THR;
  assign last_run     = (MAXF != 32'd0)
                      && ({16'd0, frame_cnt} + 32'd1 == MAXF);

  fft_sched_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .SYS_CLK   (SYS_CLK),
    .SYS_RST   (SYS_RST),
    .in_valid  (fifo_valid & inflight),
    .in_ready  (buf_rdy),
    .in_data   (fifo_dout),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata),
    .occ       (buf_occ)
  );

  a_no_overflow: assert property (
    @(posedge SYS_CLK) disable iff (SYS_RST)
    (fifo_valid && inflight) |-> buf_rdy);

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      issued     <= '0;
      sent       <= '0;
      inflight   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      inflight   <= fifo_rd_en;
      if (fifo_rd_en) issued <= issued + CW'(1);
      if (pop)        sent   <= sent + CW'(1);
      unique case (state)
        S_IDLE: begin
          if (start_en) begin
            state <= S_WAIT_FILL;
            busy  <= 1'b1;
          end
        end
        S_WAIT_FILL: begin
          if (!start_en) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (lvl_ok) begin
            state <= S_READ;
          end
        end
        S_READ: begin
          if (pop && m_axis_tlast) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          issued <= '0;
          sent   <= '0;
          if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
          if (last_run) begin
            state <= S_HALT;
          end else if (start_en) begin
            state <= S_WAIT_FILL;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_HALT: begin
          if (!start_en) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            frame_cnt <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: directed scenarios for the FFT frame scheduler
// against a simple one-cycle-latency FIFO model.
module tb_fft_frame_sched;

  logic        clk;
  logic        rst;
  logic        start_en;
  logic [10:0] fifo_level;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [47:0] fifo_dout = '0;
  logic        fifo_valid;
  logic [47:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  logic fv_q    = 1'b0;
  logic inj     = 1'b0;
  logic src_clr = 1'b0;
  int   src_idx = 0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fft_frame_sched dut (
    .SYS_CLK       (clk),
    .SYS_RST       (rst),
    .start_en      (start_en),
    .fifo_level    (fifo_level),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_dout     (fifo_dout),
    .fifo_valid    (fifo_valid),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: data is a running sample index, valid one cycle after a read
  always @(posedge clk) begin
    fv_q <= fifo_rd_en;
    if (src_clr) begin
      src_idx <= 0;
    end else if (fifo_rd_en) begin
      fifo_dout <= 48'(src_idx);
      src_idx   <= src_idx + 1;
    end
  end
  assign fifo_valid = fv_q | inj;

  task automatic test_reset;
    rst = 1'b1; start_en = 1'b0; fifo_level = '0;
    fifo_empty = 1'b0; tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({fifo_rd_en, tvalid, tlast, busy, frame_done} !== 5'b0)
      $display("FAIL rst_flags got %b want 00000",
               {fifo_rd_en, tvalid, tlast, busy, frame_done});
    else pass_cnt++;
    total_cnt++;
    if (tdata !== 48'd0) $display("FAIL rst_tdata got %0d want 0", tdata);
    else pass_cnt++;
    total_cnt++;
    if (frame_cnt !== 16'd0) $display("FAIL rst_cnt got %0d want 0", frame_cnt);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_busy got %0b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_threshold;
    bit seen_rd = 0;
    @(negedge clk);
    start_en = 1'b1; fifo_level = 11'd1499; tready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (fifo_rd_en) seen_rd = 1;
    end
    total_cnt++;
    if (seen_rd) $display("FAIL thr_hold got rd_en=1 want 0");
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL thr_busy got %0b want 1", busy);
    else pass_cnt++;
    @(negedge clk);
    fifo_level = 11'd1500; inj = 1'b1;
    #1;
    total_cnt++;
    if (fifo_rd_en !== 1'b0) $display("FAIL thr_step got rd_en=%0b want 0", fifo_rd_en);
    else pass_cnt++;
    @(negedge clk);
    inj = 1'b0; start_en = 1'b0;
    #1;
    total_cnt++;
    if ({fifo_rd_en, tvalid} !== 2'b10)
      $display("FAIL thr_read got rd/v=%b want 10", {fifo_rd_en, tvalid});
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (tvalid !== 1'b0) $display("FAIL thr_lat1 got tvalid=%0b want 0", tvalid);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (tvalid !== 1'b1 || tdata !== 48'd0)
      $display("FAIL thr_lat2 got v=%0b d=%0d want v=1 d=0", tvalid, tdata);
    else pass_cnt++;
  endtask

  task automatic test_full_frame;
    for (int i = 0; i < 512; i++) begin
      total_cnt++;
      if (tvalid !== 1'b1 || tdata !== 48'(i) || tlast !== (i == 511))
        $display("FAIL ff_beat%0d got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                 i, tvalid, tdata, tlast, i, (i == 511));
      else pass_cnt++;
      @(negedge clk);
      #1;
    end
    total_cnt++;
    if (frame_done !== 1'b1 || tvalid !== 1'b0)
      $display("FAIL ff_done got fd=%0b v=%0b want fd=1 v=0", frame_done, tvalid);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (frame_done !== 1'b0 || frame_cnt !== 16'd1 || busy !== 1'b0)
      $display("FAIL ff_after got fd=%0b cnt=%0d busy=%0b want 0 1 0",
               frame_done, frame_cnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int   beats = 0;
    int   held  = 0;
    int   n     = 0;
    logic pv = 1'b0, pr = 1'b0, prev_rd = 1'b0;
    logic [47:0] pd = '0;
    @(negedge clk);
    start_en = 1'b1; fifo_level = 11'd2047; tready = 1'($urandom_range(0, 1));
    #1;
    while (beats < 512 && n < 4000) begin
      if (pv && !pr) begin
        total_cnt++;
        if (tvalid !== 1'b1 || tdata !== pd)
          $display("FAIL bp_stable got v=%0b d=%0d want v=1 d=%0d", tvalid, tdata, pd);
        else pass_cnt++;
      end
      if (fifo_rd_en) begin
        total_cnt++;
        if (held - int'(tvalid & tready) + int'(prev_rd) >= 2)
          $display("FAIL bp_rd_gate got rd_en=1 with held=%0d inflight=%0b want 0",
                   held, prev_rd);
        else pass_cnt++;
      end
      if (tvalid && tready) begin
        total_cnt++;
        if (tdata !== 48'(512 + beats) || tlast !== (beats == 511))
          $display("FAIL bp_beat%0d got d=%0d l=%0b want d=%0d l=%0b",
                   beats, tdata, tlast, 512 + beats, (beats == 511));
        else pass_cnt++;
        beats++;
      end
      held = held + int'(fifo_valid) - int'(tvalid & tready);
      pv = tvalid; pr = tready; pd = tdata; prev_rd = fifo_rd_en;
      @(negedge clk);
      tready = 1'($urandom_range(0, 1));
      if (beats >= 256) start_en = 1'b0;
      #1;
      n++;
    end
    total_cnt++;
    if (beats != 512) $display("FAIL bp_beats got %0d want 512", beats);
    else pass_cnt++;
    total_cnt++;
    if (frame_done !== 1'b1) $display("FAIL bp_done got %0b want 1", frame_done);
    else pass_cnt++;
    tready = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if (frame_cnt !== 16'd2 || busy !== 1'b0)
      $display("FAIL bp_after got cnt=%0d busy=%0b want 2 0", frame_cnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_fifo_empty;
    int beats = 0;
    int n     = 0;
    int gap   = 0;
    bit fired = 0;
    @(negedge clk);
    start_en = 1'b1; tready = 1'b1;
    #1;
    while (beats < 512 && n < 3000) begin
      if (fifo_empty) begin
        total_cnt++;
        if (fifo_rd_en !== 1'b0) $display("FAIL em_rd got 1 want 0");
        else pass_cnt++;
      end
      if (tvalid && tready) begin
        total_cnt++;
        if (tdata !== 48'(1024 + beats) || tlast !== (beats == 511))
          $display("FAIL em_beat%0d got d=%0d l=%0b want d=%0d l=%0b",
                   beats, tdata, tlast, 1024 + beats, (beats == 511));
        else pass_cnt++;
        beats++;
      end
      @(negedge clk);
      if (beats == 200 && !fired) begin
        fifo_empty = 1'b1; gap = 10; fired = 1;
      end else if (gap > 0) begin
        gap--;
        if (gap == 0) fifo_empty = 1'b0;
      end
      if (beats >= 400) start_en = 1'b0;
      #1;
      n++;
    end
    total_cnt++;
    if (beats != 512 || frame_done !== 1'b1)
      $display("FAIL em_end got beats=%0d fd=%0b want 512 1", beats, frame_done);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (frame_cnt !== 16'd3) $display("FAIL em_cnt got %0d want 3", frame_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    int beats = 0;
    int n     = 0;
    @(negedge clk);
    start_en = 1'b1; tready = 1'b1;
    #1;
    while (beats < 300 && n < 2000) begin
      if (tvalid && tready) beats++;
      @(negedge clk);
      #1;
      n++;
    end
    rst = 1'b1; src_clr = 1'b1;
    #1;
    total_cnt++;
    if ({fifo_rd_en, tvalid, tlast, busy, frame_done} !== 5'b0 ||
        tdata !== 48'd0 || frame_cnt !== 16'd0)
      $display("FAIL mr_async got flags=%b d=%0d cnt=%0d want 00000 0 0",
               {fifo_rd_en, tvalid, tlast, busy, frame_done}, tdata, frame_cnt);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0; src_clr = 1'b0;
    #1;
    beats = 0; n = 0;
    while (beats < 512 && n < 2000) begin
      if (tvalid && tready) begin
        total_cnt++;
        if (tdata !== 48'(beats) || tlast !== (beats == 511))
          $display("FAIL mr_beat%0d got d=%0d l=%0b want d=%0d l=%0b",
                   beats, tdata, tlast, beats, (beats == 511));
        else pass_cnt++;
        beats++;
      end
      @(negedge clk);
      if (beats > 0) start_en = 1'b0;
      #1;
      n++;
    end
    @(negedge clk);
    #1;
    total_cnt++;
    if (beats != 512 || frame_cnt !== 16'd1 || busy !== 1'b0)
      $display("FAIL mr_after got beats=%0d cnt=%0d busy=%0b want 512 1 0",
               beats, frame_cnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_run_limit;
    int beats  = 0;
    int frames = 0;
    @(negedge clk);
    rst = 1'b1; src_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; src_clr = 1'b0;
    start_en = 1'b1; tready = 1'b1; fifo_level = 11'd2047;
    #1;
    for (int n = 0; n < 6000; n++) begin
      if (tvalid && tready) begin
        total_cnt++;
        if (tdata !== 48'(beats) || tlast !== (beats % 512 == 511))
          $display("FAIL rl_beat%0d got d=%0d l=%0b want d=%0d l=%0b",
                   beats, tdata, tlast, beats, (beats % 512 == 511));
        else pass_cnt++;
        beats++;
      end
      if (frame_done) frames++;
      @(negedge clk);
      #1;
    end
    total_cnt++;
    if (frames != 6 || beats != 3072)
      $display("FAIL rl_count got frames=%0d beats=%0d want 6 3072", frames, beats);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1 || fifo_rd_en !== 1'b0 || frame_cnt !== 16'd6)
      $display("FAIL rl_halt got busy=%0b rd=%0b cnt=%0d want 1 0 6",
               busy, fifo_rd_en, frame_cnt);
    else pass_cnt++;
    @(negedge clk);
    start_en = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || frame_cnt !== 16'd0)
      $display("FAIL rl_clear got busy=%0b cnt=%0d want 0 0", busy, frame_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_threshold;
    test_full_frame;
    test_backpressure;
    test_fifo_empty;
    test_reset_midframe;
    test_run_limit;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
